// File: rtl/interp_div_pkg.sv
// Shared encodings and constants for the interpolation fixed-point divider.
// INTERP_DIV_ROUND_EN adds one guard iteration for round-half-away-from-zero.
package interp_div_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PREP = 3'd1,
    ST_ITER = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_FRAC  = 16;
  localparam int MAX_W     = 64;

  // Bits in the pre-shifted dividend, i.e. magnitude-quotient width before rounding.
  function automatic int div_bits(input int width, input int frac);
    return width + frac;
  endfunction

  function automatic int div_iters(input int width, input int frac);
`ifdef INTERP_DIV_ROUND_EN
    return width + frac + 1;
`else
    return width + frac;
`endif
  endfunction

  function automatic logic [MAX_W-1:0] max_pos(input int width);
    return (64'd1 << (width - 1)) - 64'd1;
  endfunction

  function automatic logic [MAX_W-1:0] min_neg(input int width);
    return 64'd1 << (width - 1);
  endfunction

endpackage

// File: rtl/interp_div_sat.sv
// Applies sign, optional guard-bit rounding and saturation to the unsigned
// magnitude quotient produced by the restoring iterations.
module interp_div_sat
  import interp_div_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int QW    = DEF_WIDTH + DEF_FRAC
) (
  input  logic [QW-1:0]    qm_i,
  input  logic             guard_i,
  input  logic             neg_i,
  output logic [WIDTH-1:0] quotient_o,
  output logic             overflow_o
);

  localparam logic [WIDTH-1:0] MAX_POS = WIDTH'(max_pos(WIDTH));
  localparam logic [WIDTH-1:0] MIN_NEG = WIDTH'(min_neg(WIDTH));

  logic [QW:0] mag;
  logic        hi;

  assign mag = {1'b0, qm_i} + {{QW{1'b0}}, guard_i};
  // Anything at or above bit WIDTH cannot fit in either polarity.
  assign hi  = |mag[QW:WIDTH];

  always_comb begin
    quotient_o = mag[WIDTH-1:0];
    overflow_o = 1'b0;
    if (!neg_i) begin
      if (hi || mag[WIDTH-1]) begin
        quotient_o = MAX_POS;
        overflow_o = 1'b1;
      end
    end else if (hi || (mag[WIDTH-1] && (|mag[WIDTH-2:0]))) begin
      quotient_o = MIN_NEG;
      overflow_o = 1'b1;
    end else begin
      quotient_o = -mag[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/interp_fixed_divider.sv
// Sequential signed Q-format divider, quotient = (op_a << FRAC) / op_b, one bit per cycle.
// Define INTERP_DIV_ROUND_EN for round-half-away-from-zero (one extra iteration).
module interp_fixed_divider
  import interp_div_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int FRAC  = DEF_FRAC
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam int N     = div_bits(WIDTH, FRAC);
  localparam int ITERS = div_iters(WIDTH, FRAC);
  localparam int QW    = ITERS;
  localparam int CW    = (ITERS > 1) ? $clog2(ITERS) : 1;

  localparam logic [WIDTH-1:0] MAX_POS = WIDTH'(max_pos(WIDTH));
  localparam logic [WIDTH-1:0] MIN_NEG = WIDTH'(min_neg(WIDTH));

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             sign_q, sign_d;
  logic [WIDTH-1:0] bmag_q, bmag_d;
  logic [N-1:0]     dvd_q, dvd_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [QW-1:0]    qm_q, qm_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic             dbz_q, dbz_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH-1:0] amag, bmag;
  logic [WIDTH:0]   rem_shift;
  logic             rem_ge;
  logic [N-1:0]     sat_qm;
  logic             sat_guard;
  logic [WIDTH-1:0] sat_quot;
  logic             sat_ovf;

  // Unsigned magnitudes: the most negative value maps onto 2^(WIDTH-1).
  assign amag = a_q[WIDTH-1] ? -a_q : a_q;
  assign bmag = b_q[WIDTH-1] ? -b_q : b_q;

  assign rem_shift = (rem_q << 1) | (WIDTH+1)'(dvd_q[N-1]);
  assign rem_ge    = (rem_shift >= {1'b0, bmag_q});

`ifdef INTERP_DIV_ROUND_EN
  // Last iteration produced a guard bit below the result LSB.
  assign sat_qm    = qm_q[QW-1:1];
  assign sat_guard = qm_q[0];
`else
  assign sat_qm    = qm_q;
  assign sat_guard = 1'b0;
`endif

  interp_div_sat #(
    .WIDTH (WIDTH),
    .QW    (N)
  ) u_sat (
    .qm_i       (sat_qm),
    .guard_i    (sat_guard),
    .neg_i      (sign_q),
    .quotient_o (sat_quot),
    .overflow_o (sat_ovf)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sign_d  = sign_q;
    bmag_d  = bmag_q;
    dvd_d   = dvd_q;
    rem_d   = rem_q;
    qm_d    = qm_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    dbz_d   = dbz_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d     = op_a;
          b_d     = op_b;
          state_d = ST_PREP;
        end
      end
      ST_PREP: begin
        sign_d = a_q[WIDTH-1] ^ b_q[WIDTH-1];
        bmag_d = bmag;
        dvd_d  = N'(amag) << FRAC;
        rem_d  = '0;
        qm_d   = '0;
        cnt_d  = CW'(ITERS - 1);
        if (bmag == '0) begin
          quot_d  = a_q[WIDTH-1] ? MIN_NEG : MAX_POS;
          dbz_d   = 1'b1;
          ovf_d   = 1'b0;
          state_d = ST_DONE;
        end else begin
          state_d = ST_ITER;
        end
      end
      ST_ITER: begin
        rem_d = rem_ge ? (rem_shift - {1'b0, bmag_q}) : rem_shift;
        qm_d  = (qm_q << 1) | QW'(rem_ge);
        dvd_d = dvd_q << 1;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        quot_d  = sat_quot;
        ovf_d   = sat_ovf;
        dbz_d   = 1'b0;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sign_q  <= 1'b0;
      bmag_q  <= '0;
      dvd_q   <= '0;
      rem_q   <= '0;
      qm_q    <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sign_q  <= sign_d;
      bmag_q  <= bmag_d;
      dvd_q   <= dvd_d;
      rem_q   <= rem_d;
      qm_q    <= qm_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      dbz_q   <= dbz_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy        = (state_q != ST_IDLE);
  assign done        = (state_q == ST_DONE);
  assign quotient    = quot_q;
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_interp_fixed_divider.sv
// Self-checking bench for interp_fixed_divider against an arithmetic reference model.
// Honours INTERP_DIV_ROUND_EN for expected rounding and latency.
module tb_interp_fixed_divider;

`ifdef INTERP_DIV_ROUND_EN
  localparam int          LAT    = 52;
  localparam logic [31:0] EXP_23 = 32'h0000AAAB;
`else
  localparam int          LAT    = 51;
  localparam logic [31:0] EXP_23 = 32'h0000AAAA;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic        div_by_zero;
  logic        overflow;

  int total = 0;
  int bad   = 0;

  interp_fixed_divider dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .op_a        (op_a),
    .op_b        (op_b),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Real-number semantics: (a * 2^16) / b, truncated or rounded half away, then saturated.
  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] q, output logic dz, output logic ov);
    longint sa, sb, na, nb, num, qm, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (sb == 0) begin
      q  = (sa < 0) ? 32'h80000000 : 32'h7FFFFFFF;
      dz = 1'b1;
      ov = 1'b0;
    end else begin
      na  = (sa < 0) ? -sa : sa;
      nb  = (sb < 0) ? -sb : sb;
      num = na * 65536;
      qm  = num / nb;
`ifdef INTERP_DIV_ROUND_EN
      if (2 * (num % nb) >= nb) qm = qm + 1;
`endif
      r  = ((sa < 0) != (sb < 0)) ? -qm : qm;
      dz = 1'b0;
      if (r > 64'sd2147483647) begin
        q  = 32'h7FFFFFFF;
        ov = 1'b1;
      end else if (r < -64'sd2147483648) begin
        q  = 32'h80000000;
        ov = 1'b1;
      end else begin
        q  = r[31:0];
        ov = 1'b0;
      end
    end
  endfunction

  // Called right after the accepting edge; returns at the negedge of the done cycle.
  task automatic wait_done(input bit hold, output int cyc, output bit got, output bit busy_ok);
    cyc     = 0;
    got     = 1'b0;
    busy_ok = 1'b1;
    while (!got && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (done === 1'b1) got = 1'b1;
      if (!hold) start = 1'b0;
    end
  endtask

  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input bit hold,
                         input string tag);
    logic [31:0] eq;
    logic        edz, eov;
    int          cyc, lat;
    bit          got, bok;
    model(a, b, eq, edz, eov);
    lat = edz ? 2 : LAT;
    @(negedge clk);
    op_a  = a;
    op_b  = b;
    start = 1'b1;
    @(posedge clk);
    wait_done(hold, cyc, got, bok);
    check({tag, ".done"}, 32'(got), 32'd1);
    check({tag, ".lat"}, cyc, lat);
    check({tag, ".busy"}, 32'(bok), 32'd1);
    check({tag, ".q"}, quotient, eq);
    check({tag, ".dz"}, 32'(div_by_zero), 32'(edz));
    check({tag, ".ov"}, 32'(overflow), 32'(eov));
    $display("div %s a=%08h b=%08h q=%08h dz=%0b ov=%0b cycles=%0d", tag, a, b, quotient,
             div_by_zero, overflow, cyc);
    @(negedge clk);
    check({tag, ".pulse"}, 32'(done), 32'd0);
    check({tag, ".idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int          cyc, ndone;
    bit          got, bok;
    logic [31:0] ra, rb;

    rst   = 1'b0;
    start = 1'b0;
    op_a  = '0;
    op_b  = '0;
    repeat (3) @(negedge clk);
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.done", 32'(done), 32'd0);
    check("rst.q", quotient, 32'd0);
    check("rst.dz", 32'(div_by_zero), 32'd0);
    check("rst.ov", 32'(overflow), 32'd0);
    rst = 1'b1;

    run_div(32'h00030000, 32'h00020000, 1'b0, "3/2");
    check("3/2.const", quotient, 32'h00018000);
    run_div(32'hFFFF0000, 32'h00040000, 1'b0, "-1/4");
    check("-1/4.const", quotient, 32'hFFFFC000);
    run_div(32'h80000000, 32'hFFFF0000, 1'b0, "min/-1");
    run_div(32'h00050000, 32'h00000000, 1'b0, "5/0");
    run_div(32'hFFFB0000, 32'h00000000, 1'b0, "-5/0");
    run_div(32'h7FFF0000, 32'h00000100, 1'b0, "big/small");
    run_div(32'h00010000, 32'h00030000, 1'b0, "1/3");
    check("1/3.const", quotient, 32'h00005555);
    run_div(32'h00020000, 32'h00030000, 1'b0, "2/3");
    check("2/3.const", quotient, EXP_23);
    run_div(32'h00000000, 32'hFFFD0000, 1'b0, "0/neg");
    run_div(32'h80000000, 32'h00010000, 1'b0, "min/1");

    // Abort a divide in cycle 20; reset also beats a simultaneous start.
    @(negedge clk);
    op_a  = 32'h00070000;
    op_b  = 32'h00020000;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    rst   = 1'b0;
    start = 1'b1;
    @(negedge clk);
    check("abort.busy", 32'(busy), 32'd0);
    check("abort.done", 32'(done), 32'd0);
    check("abort.q", quotient, 32'd0);
    check("abort.dz", 32'(div_by_zero), 32'd0);
    check("abort.ov", 32'(overflow), 32'd0);
    @(negedge clk);
    check("rstwins.busy", 32'(busy), 32'd0);
    rst   = 1'b1;
    start = 1'b0;
    ndone = 0;
    repeat (60) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    check("abort.nodone", ndone, 0);
    run_div(32'h00070000, 32'h00020000, 1'b0, "postrst");

    // Start held high: one done per accepted start, re-accepted in first IDLE cycle.
    run_div(32'h00030000, 32'h00020000, 1'b1, "hold1");
    @(posedge clk);
    wait_done(1'b0, cyc, got, bok);
    check("hold2.done", 32'(got), 32'd1);
    check("hold2.lat", cyc, LAT);
    check("hold2.busy", 32'(bok), 32'd1);
    check("hold2.q", quotient, 32'h00018000);
    $display("div hold2 q=%08h cycles=%0d", quotient, cyc);
    @(negedge clk);
    check("hold2.idle", 32'(busy), 32'd0);

    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      case (i % 4)
        0: rb = $urandom;
        1: rb = $urandom_range(1, 65535);
        2: rb = $urandom >> $urandom_range(4, 24);
        default: begin
          rb = (i == 7) ? 32'd0 : $urandom;
          ra = ra >> $urandom_range(8, 30);
        end
      endcase
      if ($urandom_range(0, 1) == 1) rb = -rb;
      run_div(ra, rb, 1'b0, $sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/interp_fixed_divider.md
Name: interp_fixed_divider

Overview:
- Sequential signed fixed-point divider that serves the interpolation controller's `start_div` request and returns `divider_done`.
- Computes `quotient = (op_a << FRAC) / op_b` over Q(WIDTH-FRAC).FRAC operands, one quotient bit per cycle, restoring radix-2.
- Sits beside the shared multiplier in the interpolation datapath; its result feeds the `m_value` register.

Parameters:
- WIDTH, 32, operand and quotient width in bits (two's complement).
- FRAC, 16, fractional bits of operands and result; constraint 0 <= FRAC < WIDTH.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-low reset (asserted when 0).
- start  in  1  request pulse; operands are sampled only when the block is in IDLE and start=1.
- op_a  in  WIDTH  dividend, signed Q format.
- op_b  in  WIDTH  divisor, signed Q format.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse; quotient and flags are valid in the same cycle.
- quotient  out  WIDTH  signed result; held until the next done.
- div_by_zero  out  1  set with done when op_b==0; held until the next done.
- overflow  out  1  set with done when the result saturated (not set on divide by zero); held until the next done.

Behaviour:
- One clock; reset is synchronous and active-low. rst=0 at a rising edge forces the state to IDLE and clears busy, done, quotient, div_by_zero, overflow and all internal registers. Reset wins over start in the same cycle.
- Reset mid-operation aborts the divide with no done pulse. The first start accepted after reset is honoured normally.
- States: IDLE, PREP, ITER, FIX, DONE.
- IDLE: start=1 latches op_a and op_b and moves to PREP. Otherwise the state stays IDLE.
- PREP:
  - Record sign = msb(op_a) XOR msb(op_b).
  - Take the magnitudes |a| and |b| as unsigned WIDTH-bit values; -2^(WIDTH-1) maps to 2^(WIDTH-1).
  - Form the dividend |a| << FRAC, which is N = WIDTH+FRAC bits wide.
  - Clear the remainder (WIDTH+1 bits) and load iteration counter = N-1.
  - If |b|==0, go to DONE with quotient = sign_a ? 2^(WIDTH-1) : 2^(WIDTH-1)-1 and div_by_zero=1. Otherwise go to ITER.
- ITER, one cycle per bit:
  - Shift the remainder left, bringing in the dividend MSB.
  - If remainder >= |b|, subtract |b| and shift in q=1; else shift in q=0.
  - The counter decrements each cycle; at 0 the state moves to FIX.
  - This state runs exactly N cycles.
- FIX:
  - The magnitude quotient qm is N bits.
  - Non-negative result: if qm > 2^(WIDTH-1)-1, quotient = 2^(WIDTH-1)-1 and overflow=1.
  - Negative result: if qm > 2^(WIDTH-1), quotient = -2^(WIDTH-1) and overflow=1. Otherwise quotient = -qm, truncated to WIDTH bits.
  - Rounding: truncation toward zero (but see ROUND_EN).
- DONE: done=1 for this single cycle, results are registered, and the state returns to IDLE.
- start is ignored in PREP, ITER, FIX and DONE; nothing is queued. A new start may be accepted in the first IDLE cycle after DONE.
- Latency, counting the cycle after the accepting edge as cycle 1:
  - Normal divide: done in cycle N+3, which is 51 at default parameters.
  - Divide by zero: done in cycle 2.
- Zero dividend gives quotient 0 with no flags, including -0 results.

Optional Feature:
- Macro: INTERP_DIV_ROUND_EN.
- Defined:
  - ITER runs N+1 cycles to produce one guard bit below the LSB.
  - FIX adds the guard bit to the magnitude, i.e. rounds half away from zero, before the saturation check.
  - Latency becomes N+4 cycles (52 at default parameters).
- Undefined: truncation toward zero, N iterations, latency N+3.
- Port list is identical in both builds.

Decomposition:
- Package interp_div_pkg holds:
  - the state encoding localparams (IDLE..DONE, 3 bits);
  - the N / N+1 iteration-count constants;
  - the MAX_POS and MIN_NEG saturation constants, derived from WIDTH.
- One sub-module is natural: interp_div_sat, purely combinational. It takes qm, the sign and (when rounding) the guard bit, and outputs the signed WIDTH-bit quotient plus an overflow bit. It is instantiated by FIX.

Test Plan:
- a=0x00030000 (3.0), b=0x00020000 (2.0), start pulse -> quotient=0x00018000, flags 0, done in cycle 51, busy high in cycles 1..51.
- a=0xFFFF0000 (-1.0), b=0x00040000 (4.0) -> quotient=0xFFFFC000. Also a=0x80000000, b=0xFFFF0000 (-1.0) -> quotient=0x7FFFFFFF, overflow=1.
- a=0x00050000, b=0 -> quotient=0x7FFFFFFF, div_by_zero=1, overflow=0, done in cycle 2. Also a=0xFFFB0000, b=0 -> quotient=0x80000000.
- a=0x7FFF0000, b=0x00000100 (1/256) -> quotient=0x7FFFFFFF, overflow=1. Then a=0x00010000, b=0x00030000 -> quotient=0x00005555, both flags cleared.
- a=0x00020000, b=0x00030000 -> quotient=0x0000AAAA without INTERP_DIV_ROUND_EN; 0x0000AAAB with it, done in cycle 52.
- rst=0 in cycle 20 of a divide -> no done pulse and all outputs 0. start held high during busy -> exactly one done per accepted start; a start in the first IDLE cycle after done is accepted.
